// File: rtl/change_dispenser_pkg.sv
// Shared constants and state encoding for the change dispenser.
package change_pkg;

   // Coin denominations paid out, largest first.
   localparam int unsigned C5  = 5;
   localparam int unsigned C10 = 10;
   localparam int unsigned C20 = 20;

   // Default product price in coin units.
   localparam int unsigned PRICE_DEFAULT = 40;

   // Payout controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage : change_pkg

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin choice: largest denomination that still fits in the remainder.
module coin_select
   import change_pkg::*;
#(
   parameter int SW = 6,
   parameter int CW = 5
) (
   input  logic [SW-1:0] rem,
   output logic [CW-1:0] coin,
   output logic          has_coin
);

   // Pick 20, 10 or 5; anything below 5 cannot be paid.
   always_comb begin
      coin     = {CW{1'b0}};
      has_coin = 1'b0;
      if (rem >= SW'(C20)) begin
         coin     = CW'(C20);
         has_coin = 1'b1;
      end else if (rem >= SW'(C10)) begin
         coin     = CW'(C10);
         has_coin = 1'b1;
      end else if (rem >= SW'(C5)) begin
         coin     = CW'(C5);
         has_coin = 1'b1;
      end else begin
         coin     = {CW{1'b0}};
         has_coin = 1'b0;
      end
   end

endmodule : coin_select

// File: rtl/change_dispenser.sv
// Change dispenser: latches the balance on start, then pays the change
// (or a full refund) one coin per handshake using 20/10/5 greedily.
module change_dispenser
   import change_pkg::*;
#(
   parameter int PRICE = PRICE_DEFAULT,
   parameter int SW    = 6,
   parameter int CW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [SW-1:0] saldo,
   output logic [CW-1:0] coin,
   output logic          coin_valid,
   input  logic          coin_ack,
   output logic          busy,
   output logic          done,
   output logic          refund,
   output logic          short,
   output logic [3:0]    count
);

   state_t          state_r;
   state_t          state_s;
   logic [SW-1:0]   rem_r;
   logic [3:0]      count_r;
   logic            refund_r;
   logic            short_r;
   logic [CW-1:0]   sel_coin_s;
   logic            has_coin_s;
   logic            sale_s;
   logic            take_s;

   coin_select #(
      .SW (SW),
      .CW (CW)
   ) u_coin_select (
      .rem      (rem_r),
      .coin     (sel_coin_s),
      .has_coin (has_coin_s)
   );

   // Sale completes only when the balance covers the price.
   assign sale_s = (saldo >= SW'(PRICE));

   // A coin is handed over when it is offered and taken in the same cycle.
   assign take_s = (state_r == ST_OFFER) && has_coin_s && coin_ack;

   // State register; reset abandons any payout immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: wait for start, offer coins until nothing payable remains.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_OFFER;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_OFFER: begin
            if (!has_coin_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_OFFER;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Datapath: latch amount owed, decrement per paid coin, record short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_r    <= {SW{1'b0}};
         count_r  <= 4'd0;
         refund_r <= 1'b0;
         short_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  rem_r    <= sale_s ? (saldo - SW'(PRICE)) : saldo;
                  refund_r <= !sale_s;
                  count_r  <= 4'd0;
                  short_r  <= 1'b0;
               end
            end
            ST_OFFER: begin
               if (take_s) begin
                  rem_r <= rem_r - SW'(sel_coin_s);
                  if (count_r != 4'd15) begin
                     count_r <= count_r + 4'd1;
                  end
               end else if (!has_coin_s) begin
                  // Leaving for DONE: whatever is left (1..4) is unpayable.
                  short_r <= (rem_r != {SW{1'b0}});
               end
            end
            ST_DONE: begin
               rem_r <= rem_r;
            end
            default: begin
               rem_r <= rem_r;
            end
         endcase
      end
   end

   // Outputs: coin offer is gated by OFFER so stale remainders never leak.
   always_comb begin
      coin_valid = (state_r == ST_OFFER) && has_coin_s;
      if (coin_valid) begin
         coin = sel_coin_s;
      end else begin
         coin = {CW{1'b0}};
      end
   end

   assign busy   = (state_r != ST_IDLE);
   assign done   = (state_r == ST_DONE);
   assign refund = refund_r;
   assign short  = short_r;
   assign count  = count_r;

endmodule : change_dispenser

// File: tb/tb_change_dispenser.sv
// Self-checking bench: directed scenarios plus randomized transactions
// compared against a greedy-payout reference model.
module tb_change_dispenser;

   localparam int PRICE = 40;

   logic       clk;
   logic       rst;
   logic       start;
   logic [5:0] saldo;
   logic [4:0] coin;
   logic       coin_valid;
   logic       coin_ack;
   logic       busy;
   logic       done;
   logic       refund;
   logic       short;
   logic [3:0] count;

   int n_checks;
   int n_errors;

   change_dispenser #(.PRICE(PRICE), .SW(6), .CW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .saldo      (saldo),
      .coin       (coin),
      .coin_valid (coin_valid),
      .coin_ack   (coin_ack),
      .busy       (busy),
      .done       (done),
      .refund     (refund),
      .short      (short),
      .count      (count)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Run one transaction; ack_mode 0=always, 1=random, 2=low 5 cycles then high.
   task automatic run_txn(input int s, input int ack_mode);
      int q[$];
      int r;
      int owed;
      int denom[3];
      int exp_count;
      int exp_refund;
      int exp_short;
      int cyc;
      int budget;
      logic a;
      denom[0] = 20; denom[1] = 10; denom[2] = 5;
      exp_refund = (s < PRICE) ? 1 : 0;
      owed = (s >= PRICE) ? s - PRICE : s;
      r = owed;
      for (int d = 0; d < 3; d++) begin
         while (r >= denom[d]) begin
            q.push_back(denom[d]);
            r -= denom[d];
         end
      end
      exp_count = (q.size() > 15) ? 15 : q.size();
      exp_short = (r != 0) ? 1 : 0;

      @(negedge clk);
      start = 1'b1;
      saldo = 6'(s);
      coin_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      budget = 200;
      while (q.size() > 0 && budget > 0) begin
         chk("offer_valid", 32'(coin_valid), 32'd1);
         chk("offer_coin", 32'(coin), 32'(q[0]));
         chk("offer_busy", 32'(busy), 32'd1);
         chk("offer_done", 32'(done), 32'd0);
         case (ack_mode)
            0: a = 1'b1;
            1: a = ($urandom_range(0, 2) != 0);
            default: a = (cyc >= 5);
         endcase
         coin_ack = a;
         // Stray start while busy must change nothing.
         if (ack_mode == 2 && cyc == 2) begin
            start = 1'b1;
            saldo = 6'd63;
         end else begin
            start = ($urandom_range(0, 7) == 0);
            saldo = 6'($urandom_range(0, 63));
         end
         @(negedge clk);
         if (a) void'(q.pop_front());
         cyc++;
         budget--;
      end
      if (budget == 0) chk("payout_timeout", 32'd1, 32'd0);
      start = 1'b0;
      // Last OFFER cycle: nothing payable, a stray ack is ignored.
      coin_ack = $urandom_range(0, 1);
      chk("tail_valid", 32'(coin_valid), 32'd0);
      chk("tail_coin", 32'(coin), 32'd0);
      chk("tail_busy", 32'(busy), 32'd1);
      chk("tail_done", 32'(done), 32'd0);
      @(negedge clk);
      coin_ack = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_short", 32'(short), 32'(exp_short));
      chk("done_count", 32'(count), 32'(exp_count));
      chk("done_refund", 32'(refund), 32'(exp_refund));
      chk("done_valid", 32'(coin_valid), 32'd0);
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_count", 32'(count), 32'(exp_count));
      chk("idle_refund", 32'(refund), 32'(exp_refund));
   endtask

   // Stimulus sequence.
   initial begin
      int sv[6];
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      start = 1'b0;
      saldo = 6'd0;
      coin_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(coin_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_refund", 32'(refund), 32'd0);
      chk("rst_short", 32'(short), 32'd0);
      rst = 1'b0;

      // Directed: plan cases 1..5.
      run_txn(55, 0);
      run_txn(40, 0);
      run_txn(63, 0);
      run_txn(35, 0);
      run_txn(60, 2);

      // Reset while a coin is offered.
      @(negedge clk);
      start = 1'b1;
      saldo = 6'd59;
      @(negedge clk);
      start = 1'b0;
      coin_ack = 1'b1;
      chk("mid_valid", 32'(coin_valid), 32'd1);
      chk("mid_coin", 32'(coin), 32'd10);
      @(negedge clk);
      chk("mid_count", 32'(count), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(coin_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      coin_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("post_rst_done", 32'(done), 32'd0);
      run_txn(45, 0);

      // Boundary balances around the price and the maximum.
      sv[0] = 0; sv[1] = 4; sv[2] = 39; sv[3] = 41; sv[4] = 44; sv[5] = 45;
      for (int i = 0; i < 6; i++) run_txn(sv[i], 1);

      // Randomized transactions.
      for (int i = 0; i < 40; i++) run_txn($urandom_range(0, 63), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_change_dispenser
